// File: rtl/cia_pkg.sv
// Shared constants and helpers for the pipelined carry-increment adder.
package cia_pkg;

  localparam int CIA_WIDTH = 32;
  localparam int CIA_SEG   = 8;

  // Number of segments, which is also the pipeline depth.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/pipelined_carry_increment_adder_if.sv
// Operand/result bus with valid/ready on both sides; slave is the adder's view.
interface pipelined_carry_increment_adder_if
  import cia_pkg::*;
#(
  parameter int WIDTH = CIA_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, sub, carry_in, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );

  modport master (
    output in_valid, a, b, sub, carry_in, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

endinterface

// File: rtl/cia_segment.sv
// Combinational SEG-bit ripple segment: sum, carry out and carry into its MSB.
module cia_segment
  import cia_pkg::*;
#(
  parameter int SEG = CIA_SEG
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_cmsb
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (SEG+1)'(i_cin);

  // The MSB sum bit is a^b^cin at that position, so the carry into it falls out of the XOR.
  assign o_cmsb = o_sum[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];

endmodule

// File: rtl/pipelined_carry_increment_adder.sv
// Pipelined carry-increment adder/subtractor: one SEG-bit segment resolved per stage,
// operands skewed forward, resolved low segments deskewed so the result leaves aligned.
module pipelined_carry_increment_adder
  import cia_pkg::*;
#(
  parameter int WIDTH = CIA_WIDTH,
  parameter int SEG   = CIA_SEG
) (
  input logic                              clk,
  input logic                              rst,
  pipelined_carry_increment_adder_if.slave bus
);

  localparam int NSEG = nseg(WIDTH, SEG);
  localparam logic [SEG-1:0] MSB_MASK = SEG'(1) << (SEG - 1);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("pipelined_carry_increment_adder: WIDTH must be a multiple of SEG");
  end

  // Per-stage registers: skewed operands (consumed segment shifted out), resolved sum,
  // segment carry, carry into the segment MSB, and the stage valid bit.
  logic [WIDTH-1:0] r_a_p   [NSEG];
  logic [WIDTH-1:0] r_b_p   [NSEG];
  logic [WIDTH-1:0] r_s_p   [NSEG];
  logic             r_c_p   [NSEG];
  logic             r_cm_p  [NSEG];
  logic             r_vld_p [NSEG];

  // Next-state values for each stage.
  logic [WIDTH-1:0] w_a_in  [NSEG];
  logic [WIDTH-1:0] w_b_in  [NSEG];
  logic             w_vld_in[NSEG];
  logic [WIDTH-1:0] w_snext [NSEG];
  logic             w_c     [NSEG];
  logic             w_cm    [NSEG];

  logic w_stall;
  logic w_unused;

  assign w_stall      = r_vld_p[NSEG-1] & ~bus.out_ready;
  assign bus.in_ready = ~w_stall;

  // ---- stage 0: operand capture, subtract conditioning, segment 0 ----
  logic [SEG-1:0] w_sum0;
  logic           w_cin_eff;

  assign w_a_in[0]   = bus.a;
  assign w_b_in[0]   = bus.b ^ {WIDTH{bus.sub}};
  assign w_vld_in[0] = bus.in_valid;
  assign w_cin_eff   = bus.sub | bus.carry_in;

  cia_segment #(.SEG(SEG)) u_seg0 (
    .i_a    (w_a_in[0][SEG-1:0]),
    .i_b    (w_b_in[0][SEG-1:0]),
    .i_cin  (w_cin_eff),
    .o_sum  (w_sum0),
    .o_cout (w_c[0]),
    .o_cmsb (w_cm[0])
  );

  assign w_snext[0] = WIDTH'(w_sum0);

  // ---- stages 1..NSEG-1: raw segment add, then increment by the registered carry ----
  for (genvar k = 1; k < NSEG; k++) begin : g_stage
    logic [SEG-1:0] w_raw;
    logic [SEG-1:0] w_seg;
    logic           w_craw;
    logic           w_cmraw;

    assign w_a_in[k]   = r_a_p[k-1];
    assign w_b_in[k]   = r_b_p[k-1];
    assign w_vld_in[k] = r_vld_p[k-1];

    cia_segment #(.SEG(SEG)) u_seg (
      .i_a    (w_a_in[k][SEG-1:0]),
      .i_b    (w_b_in[k][SEG-1:0]),
      .i_cin  (1'b0),
      .o_sum  (w_raw),
      .o_cout (w_craw),
      .o_cmsb (w_cmraw)
    );

    assign w_seg      = w_raw + SEG'(r_c_p[k-1]);
    assign w_c[k]     = w_craw | (r_c_p[k-1] & (&w_raw));
    // The increment reaches the MSB only if every bit below it in the raw sum is one.
    assign w_cm[k]    = w_cmraw | (r_c_p[k-1] & (&(w_raw | MSB_MASK)));
    assign w_snext[k] = r_s_p[k-1] | (WIDTH'(w_seg) << (k * SEG));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld_p[k] <= 1'b0;
        r_a_p[k]   <= '0;
        r_b_p[k]   <= '0;
        r_s_p[k]   <= '0;
        r_c_p[k]   <= 1'b0;
        r_cm_p[k]  <= 1'b0;
      end
    end else if (!w_stall) begin
      for (int k = 0; k < NSEG; k++) begin
        r_vld_p[k] <= w_vld_in[k];
        r_a_p[k]   <= w_a_in[k] >> SEG;
        r_b_p[k]   <= w_b_in[k] >> SEG;
        r_s_p[k]   <= w_snext[k];
        r_c_p[k]   <= w_c[k];
        r_cm_p[k]  <= w_cm[k];
      end
    end
  end

  // ---- output: last stage drives the result bus ----
  assign bus.out_valid = r_vld_p[NSEG-1];
  assign bus.sum       = r_s_p[NSEG-1];
  assign bus.carry_out = r_c_p[NSEG-1];
  assign bus.overflow  = r_c_p[NSEG-1] ^ r_cm_p[NSEG-1];

  assign w_unused = ^{r_a_p[NSEG-1], r_b_p[NSEG-1]};

endmodule

// File: tb/tb_pipelined_carry_increment_adder.sv
// Bench for the pipelined carry-increment adder: 32/8 instance checked against a
// queue-based arithmetic model, plus a 16/16 instance for the single-stage case.
module tb_pipelined_carry_increment_adder;

  localparam int LAT   = 4;
  localparam int LAT16 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipelined_carry_increment_adder_if #(.WIDTH(32)) bus ();
  pipelined_carry_increment_adder_if #(.WIDTH(16)) bus16 ();

  pipelined_carry_increment_adder #(.WIDTH(32), .SEG(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipelined_carry_increment_adder #(.WIDTH(16), .SEG(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t q[$];
  int   consumed     = 0;
  int   cyc          = 0;
  int   first_out    = -1;
  int   last_out     = -1;
  int   stall_cycles = 0;
  res_t prev;
  logic prev_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Arithmetic model: subtraction as two's-complement add, overflow from operand signs.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    res_t        r;
    logic [31:0] be;
    logic [32:0] full;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + 33'(sub ? 1'b1 : cin);
    r.sum  = full[31:0];
    r.co   = full[32];
    r.ov   = (a[31] == be[31]) && (full[31] != a[31]);
    return r;
  endfunction

  // Compare process: checks every cycle away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
      if (!bus.in_ready) stall_cycles++;
      if (bus.out_valid) begin
        if (prev_stall) chk("stall_hold", 64'({bus.sum, bus.carry_out, bus.overflow}), 64'(prev));
        chk("out_has_pending", 64'(q.size() > 0), 64'd1);
        if (q.size() > 0) begin
          chk("result", 64'({bus.sum, bus.carry_out, bus.overflow}), 64'(q[0]));
          if (bus.out_ready) begin
            void'(q.pop_front());
            consumed++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
          end
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev       = {bus.sum, bus.carry_out, bus.overflow};
      if (bus.in_valid && bus.in_ready) q.push_back(model(bus.a, bus.b, bus.sub, bus.carry_in));
    end
  end

  task automatic send32(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic cin,
                        input logic [31:0] es, input logic eco, input logic eov);
    int n;
    bus.a = a; bus.b = b; bus.sub = sub; bus.carry_in = cin;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LAT));
    chk({nm, "_sum"}, 64'(bus.sum), 64'(es));
    chk({nm, "_carry"}, 64'(bus.carry_out), 64'(eco));
    chk({nm, "_ovf"}, 64'(bus.overflow), 64'(eov));
    @(posedge clk); #1;
  endtask

  task automatic send16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic [15:0] es, input logic eco, input logic eov);
    int n;
    bus16.a = a; bus16.b = b; bus16.sub = sub; bus16.carry_in = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    n = 1;
    while (!bus16.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(LAT16));
    chk({nm, "_sum"}, 64'(bus16.sum), 64'(es));
    chk({nm, "_carry"}, 64'(bus16.carry_out), 64'(eco));
    chk({nm, "_ovf"}, 64'(bus16.overflow), 64'(eov));
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 64'(bus16.out_valid), 64'd0);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (q.size() > 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int          base;
    int          idx;
    int          c;
    logic        rdy;
    logic [31:0] va[8];
    logic [31:0] vb[8];
    logic        vs[8];

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.carry_in = 1'b0;
    bus.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sub = 1'b0;
    bus16.carry_in = 1'b0; bus16.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_carry", 64'(bus.carry_out), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst16_out_valid", 64'(bus16.out_valid), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Directed vectors
    send32("add_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    send32("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send32("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    send32("add_cin",   32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    send32("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    send32("sub_zero",  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    // Back-to-back stream
    base = consumed;
    first_out = -1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.a = $urandom; bus.b = $urandom;
      bus.sub = 1'($urandom_range(1)); bus.carry_in = 1'($urandom_range(1));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain(20);
    chk("stream_count", 64'(consumed - base), 64'd100);
    chk("stream_contiguous", 64'(last_out - first_out + 1), 64'd100);

    // Backpressure
    for (int i = 0; i < 8; i++) begin
      va[i] = $urandom; vb[i] = $urandom; vs[i] = 1'($urandom_range(1));
    end
    base = consumed;
    stall_cycles = 0;
    idx = 0;
    c = 0;
    while (idx < 8 && c < 50) begin
      bus.out_ready = !(c >= 5 && c <= 7);
      bus.in_valid = 1'b1;
      bus.a = va[idx]; bus.b = vb[idx]; bus.sub = vs[idx]; bus.carry_in = ~vs[idx];
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (rdy) idx++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drain(20);
    chk("bp_accepted", 64'(idx), 64'd8);
    chk("bp_count", 64'(consumed - base), 64'd8);
    chk("bp_stall_cycles", 64'(stall_cycles), 64'd3);

    // Reset flush
    for (int i = 0; i < 3; i++) begin
      bus.a = 32'h0000_1000 * i; bus.b = 32'h0000_0011; bus.sub = 1'b0; bus.carry_in = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("flush_in_ready_rst", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_no_valid", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk); #1;
    send32("after_flush", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0);

    // Single-stage instance
    send16("deg_ovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send16("deg_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send16("deg_sub",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
